// File: rtl/zero_run_scanner.sv
// Multi-cycle leading/trailing zero/one counter: scans a latched word CHUNK_WIDTH
// bits per clock from the low end and stops at the first chunk containing a hit.
module zero_run_scanner #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic [1:0]                  mode,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [$clog2(DATA_WIDTH):0] dout,
  output logic                        dout_valid,
  input  logic                        dout_ready
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  word_q, norm;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       count_q, dout_q, tz, next_count;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic                   hit, last;

  // Every mode is reduced to a trailing-zero count on the normalised word.
  always_comb begin
    norm = din;
    if (mode[0]) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        norm[i] = din[DATA_WIDTH-1-i];
      end
    end
    if (mode[1]) begin
      norm = ~norm;
    end
  end

  always_comb begin
    chunk = '0;
    for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
      if (idx_q == IDX_W'(c)) begin
        chunk = word_q[c*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  // Scanning from the MSB down leaves the lowest set bit's position in tz.
  always_comb begin
    tz = '0;
    for (int unsigned i = 0; i < CHUNK_WIDTH; i++) begin
      if (chunk[CHUNK_WIDTH-1-i]) begin
        tz = CNT_W'(CHUNK_WIDTH - 1 - i);
      end
    end
  end

  always_comb begin
    hit  = |chunk;
    last = (idx_q == IDX_W'(NUM_CHUNKS - 1));
    if (hit) begin
      next_count = count_q + tz;
    end else if (last) begin
      next_count = CNT_W'(DATA_WIDTH);
    end else begin
      next_count = count_q + CNT_W'(CHUNK_WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (din_valid) state_d = SCAN;
      SCAN:    if (hit || last) state_d = DONE;
      DONE:    if (dout_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready  = (state_q == IDLE);
    dout_valid = (state_q == DONE);
    dout       = dout_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            word_q  <= norm;
            idx_q   <= '0;
            count_q <= '0;
          end
        end
        SCAN: begin
          count_q <= next_count;
          if (hit || last) begin
            dout_q <= next_count;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_run_scanner.sv
// Bench for zero_run_scanner: three chunk widths share one stimulus stream; a
// scoreboard holds expected count and latency per instance.
module tb_zero_run_scanner;

  logic        clk = 1'b0;
  logic        resetn, din_valid, dout_ready;
  logic [31:0] din;
  logic [1:0]  mode;
  logic [2:0]  din_ready_w, dout_valid_w;
  logic [5:0]  dout_w [3];

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int acc_edge [3];
  int cw_of [3] = '{8, 32, 4};
  int sb [3][$];
  int mon_e;
  logic [5:0] held [3];
  logic [5:0] last_dout [3];
  bit active [3];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  zero_run_scanner #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) u_c8 (
    .clk(clk), .resetn(resetn), .din(din), .mode(mode), .din_valid(din_valid),
    .din_ready(din_ready_w[0]), .dout(dout_w[0]), .dout_valid(dout_valid_w[0]),
    .dout_ready(dout_ready));

  zero_run_scanner #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) u_c32 (
    .clk(clk), .resetn(resetn), .din(din), .mode(mode), .din_valid(din_valid),
    .din_ready(din_ready_w[1]), .dout(dout_w[1]), .dout_valid(dout_valid_w[1]),
    .dout_ready(dout_ready));

  zero_run_scanner #(.DATA_WIDTH(32), .CHUNK_WIDTH(4)) u_c4 (
    .clk(clk), .resetn(resetn), .din(din), .mode(mode), .din_valid(din_valid),
    .din_ready(din_ready_w[2]), .dout(dout_w[2]), .dout_valid(dout_valid_w[2]),
    .dout_ready(dout_ready));

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic int ref_count(logic [31:0] d, logic [1:0] m);
    logic [31:0] v;
    int n;
    v = m[1] ? ~d : d;
    n = 0;
    if (m[0]) begin
      while (n < 32 && v[31-n] == 1'b0) n++;
    end else begin
      while (n < 32 && v[n] == 1'b0) n++;
    end
    return n;
  endfunction

  function automatic int ref_lat(int cnt, int cw);
    return (cnt == 32) ? 32 / cw : cnt / cw + 1;
  endfunction

  task automatic push_exp(logic [31:0] d, logic [1:0] m);
    int cnt;
    cnt = ref_count(d, m);
    for (int k = 0; k < 3; k++) sb[k].push_back(ref_lat(cnt, cw_of[k]) * 256 + cnt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (din_ready_w !== 3'b111 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 0, din_ready_w, 3'b111);
  endtask

  task automatic send(logic [31:0] d, logic [1:0] m);
    wait_idle();
    din = d;
    mode = m;
    din_valid = 1'b1;
    push_exp(d, m);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (!resetn) begin
      for (int k = 0; k < 3; k++) begin
        last_dout[k] = '0;
        active[k] = 1'b0;
      end
    end
  end

  // Result monitor: first cycle of dout_valid pops the scoreboard, later cycles
  // check that dout holds; outside DONE dout must keep the last delivered value.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (resetn && din_valid && din_ready_w[k]) acc_edge[k] = edge_cnt + 1;
        if (dout_valid_w[k]) begin
          check("ready_low_in_done", k, din_ready_w[k], 0);
          if (!active[k]) begin
            check("result_expected", k, sb[k].size() > 0, 1);
            if (sb[k].size() > 0) begin
              mon_e = sb[k].pop_front();
              check("dout", k, dout_w[k], mon_e % 256);
              check("latency", k, edge_cnt - acc_edge[k], mon_e / 256);
              held[k] = 6'(mon_e % 256);
            end
            active[k] = 1'b1;
          end else begin
            check("dout_hold", k, dout_w[k], held[k]);
          end
          last_dout[k] = held[k];
          if (dout_ready) active[k] = 1'b0;
        end else begin
          active[k] = 1'b0;
          check("dout_idle_hold", k, dout_w[k], last_dout[k]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    din_valid = 1'b1;
    din = 32'h0000_0005;
    mode = 2'b00;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_din_ready", k, din_ready_w[k], 1);
      check("rst_dout_valid", k, dout_valid_w[k], 0);
      check("rst_dout", k, dout_w[k], 0);
    end
    resetn = 1'b1;
    din_valid = 1'b0;
    mon_en = 1'b1;

    send(32'h0000_0100, 2'b00);
    send(32'h0000_0000, 2'b00);
    send(32'h0000_0001, 2'b00);
    send(32'h0000_FFFF, 2'b01);
    send(32'hFFFF_FFFF, 2'b11);
    send(32'h0000_00FF, 2'b10);
    send(32'h0800_0000, 2'b00);
    send(32'h0000_0010, 2'b01);
    for (int i = 0; i < 10; i++) begin
      send($urandom >> $urandom_range(0, 31), 2'($urandom_range(0, 3)));
    end

    // Backpressure with a second word waiting on din the whole time.
    wait_idle();
    dout_ready = 1'b0;
    din = 32'h8000_0000;
    mode = 2'b00;
    din_valid = 1'b1;
    push_exp(32'h8000_0000, 2'b00);
    @(posedge clk); #1;
    din = 32'h0000_0000;
    push_exp(32'h0000_0000, 2'b00);
    n = 0;
    while (dout_valid_w !== 3'b111 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_all_done", 0, dout_valid_w, 3'b111);
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", k, dout_valid_w[k], 1);
      check("bp_ready", k, din_ready_w[k], 0);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_release_idle", k, din_ready_w[k], 1);
      check("bp_release_valid", k, dout_valid_w[k], 0);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) check("bp_next_accept", k, din_ready_w[k], 0);

    // Reset at the second scan edge; only the single-chunk instance finishes first.
    wait_idle();
    din = 32'h0000_0000;
    mode = 2'b00;
    din_valid = 1'b1;
    sb[1].push_back(1 * 256 + 32);
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("mid_rst_dout_valid", k, dout_valid_w[k], 0);
      check("mid_rst_dout", k, dout_w[k], 0);
      check("mid_rst_din_ready", k, din_ready_w[k], 1);
    end
    repeat (12) @(posedge clk);
    #1;

    send(32'h0000_0100, 2'b00);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("sb_empty", k, sb[k].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
